// File: rtl/divider_stg_1_pkg.sv
// Shared parameters and state encoding for the restoring shift-subtract divider.
package divider_stg_1_pkg;
  localparam int L_WORD_DEF  = 4;
  localparam int L_STATE_DEF = 2;

  typedef enum logic [L_STATE_DEF-1:0] {
    S_idle = 2'd0,
    S_run  = 2'd1,
    S_done = 2'd2
  } state_t;
endpackage

// File: rtl/divider_stg_controller.sv
// State-transition-graph controller: state register, iteration counter and
// control decodes that steer the divider datapath.
module divider_stg_controller
  import divider_stg_1_pkg::*;
#(
  parameter int L_word  = L_WORD_DEF,
  parameter int L_state = L_STATE_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_start,
  input  logic i_w1_zero,
  input  logic i_w2_zero,
  input  logic i_trial_neg,
  output logic o_ready,
  output logic o_load_words,
  output logic o_sub_shift,
  output logic o_shift,
  output logic o_load_zero,
  output logic o_load_err,
  output logic o_done
);
  localparam int CW = (L_word > 1) ? $clog2(L_word) : 1;

  logic [L_state-1:0] r_state;
  logic [L_state-1:0] w_state_next;
  logic [CW-1:0]      r_count;
  logic               w_run;
  logic               w_last;
  logic               w_accept;

  assign w_run    = (r_state == L_state'(S_run));
  assign w_last   = (r_count == CW'(L_word - 1));
  assign o_ready  = (r_state == L_state'(S_idle)) || (r_state == L_state'(S_done));
  assign w_accept = o_ready && i_start;

  // Zero-divisor check outranks zero-dividend shortcut, which outranks a real run.
  assign o_load_err   = w_accept && i_w2_zero;
  assign o_load_zero  = w_accept && !i_w2_zero && i_w1_zero;
  assign o_load_words = w_accept && !i_w2_zero && !i_w1_zero;
  assign o_sub_shift  = w_run && !i_trial_neg;
  assign o_shift      = w_run && i_trial_neg;
  assign o_done       = w_run && w_last;

  // Next-state decode; unused encodings recover to idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      L_state'(S_idle), L_state'(S_done): begin
        if (o_load_words) begin
          w_state_next = L_state'(S_run);
        end else if (o_load_err || o_load_zero) begin
          w_state_next = L_state'(S_done);
        end else begin
          w_state_next = r_state;
        end
      end
      L_state'(S_run): begin
        if (w_last) begin
          w_state_next = L_state'(S_done);
        end else begin
          w_state_next = L_state'(S_run);
        end
      end
      default: w_state_next = L_state'(S_idle);
    endcase
  end

  // State register and iteration counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= L_state'(S_idle);
      r_count <= {CW{1'b0}};
    end else begin
      r_state <= w_state_next;
      if (o_load_words) begin
        r_count <= {CW{1'b0}};
      end else if (w_run) begin
        r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_count <= r_count;
      end
    end
  end
endmodule

// File: rtl/divider_stg_1.sv
// Unsigned restoring divider top: datapath registers and trial subtractor,
// sequenced by divider_stg_controller.
module divider_stg_1
  import divider_stg_1_pkg::*;
#(
  parameter int L_word  = L_WORD_DEF,
  parameter int L_state = L_STATE_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [L_word-1:0] word1,
  input  logic [L_word-1:0] word2,
  input  logic              Start,
  output logic [L_word-1:0] quotient,
  output logic [L_word-1:0] remainder,
  output logic              Ready,
  output logic              Error
);
  logic [L_word-1:0] r_dividend;
  logic [L_word-1:0] r_divisor;
  logic [L_word-1:0] r_prem;
  logic [L_word-1:0] r_qwork;
  logic [L_word-1:0] r_quotient;
  logic [L_word-1:0] r_remainder;
  logic              r_error;

  logic [L_word:0]   w_trial;
  logic              w_trial_neg;
  logic [L_word-1:0] w_prem_next;
  logic [L_word-1:0] w_q_next;
  logic              w_load_words;
  logic              w_sub_shift;
  logic              w_shift;
  logic              w_load_zero;
  logic              w_load_err;
  logic              w_done;

  divider_stg_controller #(.L_word(L_word), .L_state(L_state)) u_ctrl (
    .clock        (clock),
    .reset        (reset),
    .i_start      (Start),
    .i_w1_zero    (word1 == {L_word{1'b0}}),
    .i_w2_zero    (word2 == {L_word{1'b0}}),
    .i_trial_neg  (w_trial_neg),
    .o_ready      (Ready),
    .o_load_words (w_load_words),
    .o_sub_shift  (w_sub_shift),
    .o_shift      (w_shift),
    .o_load_zero  (w_load_zero),
    .o_load_err   (w_load_err),
    .o_done       (w_done)
  );

  // One extra bit so the borrow lands in the sign position.
  assign w_trial     = {r_prem, r_dividend[L_word-1]} - {1'b0, r_divisor};
  assign w_trial_neg = w_trial[L_word];
  assign w_q_next    = {r_qwork[L_word-2:0], ~w_trial_neg};

  // Restore on borrow: keep the shifted partial remainder instead of the difference.
  always_comb begin
    w_prem_next = w_trial[L_word-1:0];
    if (w_trial_neg) begin
      w_prem_next = {r_prem[L_word-2:0], r_dividend[L_word-1]};
    end else begin
      w_prem_next = w_trial[L_word-1:0];
    end
  end

  // Working registers for the iteration.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_dividend <= {L_word{1'b0}};
      r_divisor  <= {L_word{1'b0}};
      r_prem     <= {L_word{1'b0}};
      r_qwork    <= {L_word{1'b0}};
    end else if (w_load_words) begin
      r_dividend <= word1;
      r_divisor  <= word2;
      r_prem     <= {L_word{1'b0}};
      r_qwork    <= {L_word{1'b0}};
    end else if (w_sub_shift || w_shift) begin
      r_dividend <= {r_dividend[L_word-2:0], 1'b0};
      r_prem     <= w_prem_next;
      r_qwork    <= w_q_next;
    end else begin
      r_dividend <= r_dividend;
      r_prem     <= r_prem;
      r_qwork    <= r_qwork;
    end
  end

  // Visible results change only on completion, a shortcut, or reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_quotient  <= {L_word{1'b0}};
      r_remainder <= {L_word{1'b0}};
      r_error     <= 1'b0;
    end else if (w_load_err) begin
      r_quotient  <= {L_word{1'b1}};
      r_remainder <= word1;
      r_error     <= 1'b1;
    end else if (w_load_zero) begin
      r_quotient  <= {L_word{1'b0}};
      r_remainder <= {L_word{1'b0}};
      r_error     <= 1'b0;
    end else if (w_load_words) begin
      r_error     <= 1'b0;
    end else if (w_done) begin
      r_quotient  <= w_q_next;
      r_remainder <= w_prem_next;
    end else begin
      r_quotient  <= r_quotient;
      r_remainder <= r_remainder;
      r_error     <= r_error;
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign Error     = r_error;
endmodule
